// File: rtl/mii_io_rx_pkg.sv
// mii_io_rx_pkg: shared constants, pin-nibble type and the receive sanitising
// function for the MII receive pin block.
//   MII_DIV_DEF        clk cycles per rx_clk period at 100 Mbit/s
//   MII_SLOW_MULT_DEF  period multiplier in 10 Mbit/s mode
//   MII_FALSE_CARRIER  rxd code driven for valid=0, err=1
package mii_io_rx_pkg;

  localparam int unsigned MII_DIV_DEF       = 5;
  localparam int unsigned MII_SLOW_MULT_DEF = 10;
  localparam logic [3:0]  MII_FALSE_CARRIER = 4'hE;

  // One nibble as it appears on the pins.
  typedef struct packed {
    logic       dv;
    logic       er;
    logic [3:0] d;
  } mii_nibble_t;

  // Map the core's valid/err/data onto legal MII receive pin values.
  function automatic mii_nibble_t mii_sanitise(input logic       valid,
                                               input logic       err,
                                               input logic [3:0] data);
    mii_nibble_t n;
    n.dv = valid;
    n.er = err;
    if (valid) begin
      n.d = data;
    end else if (err) begin
      n.d = MII_FALSE_CARRIER;
    end else begin
      n.d = 4'h0;
    end
    return n;
  endfunction

endpackage

// File: rtl/mii_io_rx_if.sv
// mii_io_rx_if: core-side and pin-side signals of the MII receive pin block.
//   speed_10          1 = 10 Mbit/s period (quasi-static)
//   ce                one-cycle strobe per MII nibble period
//   valid/err/data    core receive nibble, sampled when ce=1
//   rx_clk            off-chip receive clock
//   rx_dv/rx_er/rxd   off-chip receive pins
// master: the pin block; slave: the core / pad side driving and observing it.
interface mii_io_rx_if;
  logic       speed_10;
  logic       ce;
  logic       valid;
  logic       err;
  logic [3:0] data;
  logic       rx_clk;
  logic       rx_dv;
  logic       rx_er;
  logic [3:0] rxd;

  modport master (
    input  speed_10, valid, err, data,
    output ce, rx_clk, rx_dv, rx_er, rxd
  );

  modport slave (
    output speed_10, valid, err, data,
    input  ce, rx_clk, rx_dv, rx_er, rxd
  );
endinterface

// File: rtl/mii_io_rx_clk_gen.sv
// mii_clk_gen: MII period generator driven from the fast core clock.
//   clk         core clock
//   rst_n       asynchronous active-low reset
//   i_speed_10  1 = period DIV*SLOW_MULT, else DIV; latched only at period wrap
//   o_ce        registered, high in the first cycle of each period (rx_clk just rose)
//   o_rx_clk    registered, high for the first ceil(P/2) cycles of each period
//   o_fall      combinational, high in the cycle whose closing edge drops rx_clk
// The down-count cnt = P-1..0 is kept as an up-count of elapsed cycles so the
// reset value is the constant 0 regardless of speed.
module mii_clk_gen #(
  parameter int unsigned DIV       = 5,  // must be >= 3
  parameter int unsigned SLOW_MULT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_speed_10,
  output logic o_ce,
  output logic o_rx_clk,
  output logic o_fall
);

  localparam int unsigned PFast = DIV;
  localparam int unsigned PSlow = DIV * SLOW_MULT;
  localparam int unsigned CntW  = $clog2(PSlow);

  localparam logic [CntW-1:0] LastFast = CntW'(PFast - 1);
  localparam logic [CntW-1:0] LastSlow = CntW'(PSlow - 1);
  // Last elapsed value with rx_clk high, i.e. cnt == P/2.
  localparam logic [CntW-1:0] HighFast = CntW'(PFast - 1 - PFast / 2);
  localparam logic [CntW-1:0] HighSlow = CntW'(PSlow - 1 - PSlow / 2);

  logic [CntW-1:0] r_elapsed;
  logic            r_speed;
  logic            r_init;
  logic            r_ce;
  logic            r_rx_clk;

  logic [CntW-1:0] w_elapsed_d;
  logic [CntW-1:0] w_last;
  logic [CntW-1:0] w_high_end;
  logic [CntW-1:0] w_high_end_d;
  logic            w_speed;
  logic            w_speed_d;
  logic            w_wrap;

  always_comb begin
    // Until the first edge after reset the live input defines the first period.
    w_speed      = r_init ? i_speed_10 : r_speed;
    w_last       = w_speed ? LastSlow : LastFast;
    w_high_end   = w_speed ? HighSlow : HighFast;
    w_wrap       = (r_elapsed == w_last);
    w_elapsed_d  = w_wrap ? '0 : r_elapsed + CntW'(1);
    w_speed_d    = w_wrap ? i_speed_10 : w_speed;
    w_high_end_d = w_speed_d ? HighSlow : HighFast;
    o_fall       = (r_elapsed == w_high_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_elapsed <= '0;
      r_speed   <= 1'b0;
      r_init    <= 1'b1;
      r_ce      <= 1'b0;
      r_rx_clk  <= 1'b0;
    end else begin
      r_elapsed <= w_elapsed_d;
      r_speed   <= w_speed_d;
      r_init    <= 1'b0;
      r_ce      <= w_wrap;
      r_rx_clk  <= (w_elapsed_d <= w_high_end_d);
    end
  end

  assign o_ce     = r_ce;
  assign o_rx_clk = r_rx_clk;

endmodule

// File: rtl/mii_io_rx.sv
// mii_io_rx: PHY-side MII receive pin block.
//   clk    core clock (only clock)
//   rst_n  asynchronous active-low reset; pins drop to 0 immediately
//   bus    mii_io_rx_if.master: speed_10/valid/err/data in, ce/rx_clk/rx_dv/rx_er/rxd out
// The core nibble is captured and sanitised on ce, then moved to the pin
// registers on the edge that drops rx_clk, so the pins are stable for a full
// rx_clk period around the MAC's rising-edge sample.
module mii_io_rx
  import mii_io_rx_pkg::*;
#(
  parameter int unsigned DIV       = MII_DIV_DEF,
  parameter int unsigned SLOW_MULT = MII_SLOW_MULT_DEF
) (
  input logic         clk,
  input logic         rst_n,
  mii_io_rx_if.master bus
);

  logic        w_ce;
  logic        w_rx_clk;
  logic        w_fall;
  mii_nibble_t r_hold;
  mii_nibble_t r_pins;

  mii_clk_gen #(
    .DIV       (DIV),
    .SLOW_MULT (SLOW_MULT)
  ) u_clk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_speed_10 (bus.speed_10),
    .o_ce       (w_ce),
    .o_rx_clk   (w_rx_clk),
    .o_fall     (w_fall)
  );

  // r_pins maps onto registered output IO cells.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_pins <= '0;
    end else begin
      if (w_ce) begin
        r_hold <= mii_sanitise(bus.valid, bus.err, bus.data);
      end
      if (w_fall) begin
        r_pins <= r_hold;
      end
    end
  end

  assign bus.ce     = w_ce;
  assign bus.rx_clk = w_rx_clk;
  assign bus.rx_dv  = r_pins.dv;
  assign bus.rx_er  = r_pins.er;
  assign bus.rxd    = r_pins.d;

endmodule

// File: tb/tb_mii_io_rx.sv
module tb_mii_io_rx;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mii_io_rx_if bus_if ();

  mii_io_rx #(
    .DIV       (5),
    .SLOW_MULT (10)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;

  // Pin values expected from the previous nibble period.
  logic       prev_dv;
  logic       prev_er;
  logic [3:0] prev_d;

  task automatic step();
    @(negedge clk);
  endtask

  // Reset state, then free-run at DIV=5 with idle core inputs.
  task automatic test_reset();
    logic [1:10] clk_pat;
    logic [1:10] ce_pat;
    clk_pat = 10'b1100111001;
    ce_pat  = 10'b0000100001;
    rst_n = 1'b0;
    bus_if.speed_10 = 1'b0;
    bus_if.valid = 1'b0;
    bus_if.err   = 1'b0;
    bus_if.data  = 4'h0;
    repeat (3) step();
    rst_n = 1'b1;
    total++;
    if (bus_if.rx_clk !== 1'b0 || bus_if.ce !== 1'b0 || bus_if.rx_dv !== 1'b0 ||
        bus_if.rx_er !== 1'b0 || bus_if.rxd !== 4'h0) begin
      bad++;
      $display("FAIL reset_state: rx_clk=%b ce=%b rx_dv=%b rx_er=%b rxd=%h, want all 0",
               bus_if.rx_clk, bus_if.ce, bus_if.rx_dv, bus_if.rx_er, bus_if.rxd);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (bus_if.rx_clk !== clk_pat[k] || bus_if.ce !== ce_pat[k]) begin
        bad++;
        $display("FAIL freerun_clk_ce k=%0d: rx_clk=%b ce=%b, want rx_clk=%b ce=%b",
                 k, bus_if.rx_clk, bus_if.ce, clk_pat[k], ce_pat[k]);
      end
      total++;
      if (bus_if.rx_dv !== 1'b0 || bus_if.rx_er !== 1'b0 || bus_if.rxd !== 4'h0) begin
        bad++;
        $display("FAIL freerun_pins k=%0d: rx_dv=%b rx_er=%b rxd=%h, want 0 0 0",
                 k, bus_if.rx_dv, bus_if.rx_er, bus_if.rxd);
      end
    end
    prev_dv = 1'b0;
    prev_er = 1'b0;
    prev_d  = 4'h0;
  endtask

  // Entered at a ce cycle: 7 nibbles of 5 then one D, valid=1, err=0.
  task automatic test_data();
    logic [3:0] nib;
    for (int j = 0; j < 8; j++) begin
      nib = (j < 7) ? 4'h5 : 4'hD;
      bus_if.valid = 1'b1;
      bus_if.err   = 1'b0;
      bus_if.data  = nib;
      repeat (2) step();
      total++;
      if (bus_if.rx_dv !== prev_dv || bus_if.rxd !== prev_d) begin
        bad++;
        $display("FAIL data_hold j=%0d: rx_dv=%b rxd=%h, want %b %h",
                 j, bus_if.rx_dv, bus_if.rxd, prev_dv, prev_d);
      end
      step();
      total++;
      if (bus_if.rx_dv !== 1'b1 || bus_if.rx_er !== 1'b0 || bus_if.rxd !== nib) begin
        bad++;
        $display("FAIL data_latency j=%0d: rx_dv=%b rx_er=%b rxd=%h, want 1 0 %h",
                 j, bus_if.rx_dv, bus_if.rx_er, bus_if.rxd, nib);
      end
      repeat (2) step();
      total++;
      if (bus_if.ce !== 1'b1 || bus_if.rx_clk !== 1'b1 || bus_if.rxd !== nib ||
          bus_if.rx_dv !== 1'b1) begin
        bad++;
        $display("FAIL data_at_rise j=%0d: ce=%b rx_clk=%b rx_dv=%b rxd=%h, want 1 1 1 %h",
                 j, bus_if.ce, bus_if.rx_clk, bus_if.rx_dv, bus_if.rxd, nib);
      end
      prev_dv = 1'b1;
      prev_er = 1'b0;
      prev_d  = nib;
    end
  endtask

  // Entered at a ce cycle: false carrier, idle, mid-frame error, clean data.
  task automatic test_sanitise();
    logic [3:0]  v_in;
    logic [3:0]  e_in;
    logic [15:0] d_in;
    logic [3:0]  dv_exp;
    logic [3:0]  er_exp;
    logic [15:0] d_exp;
    v_in   = 4'b1100;
    e_in   = 4'b0101;
    d_in   = {4'hA, 4'hA, 4'h3, 4'h3};
    dv_exp = 4'b1100;
    er_exp = 4'b0101;
    d_exp  = {4'hA, 4'hA, 4'h0, 4'hE};
    for (int j = 0; j < 4; j++) begin
      bus_if.valid = v_in[j];
      bus_if.err   = e_in[j];
      bus_if.data  = d_in[j*4 +: 4];
      repeat (2) step();
      total++;
      if (bus_if.rx_dv !== prev_dv || bus_if.rx_er !== prev_er || bus_if.rxd !== prev_d) begin
        bad++;
        $display("FAIL sanitise_hold j=%0d: rx_dv=%b rx_er=%b rxd=%h, want %b %b %h",
                 j, bus_if.rx_dv, bus_if.rx_er, bus_if.rxd, prev_dv, prev_er, prev_d);
      end
      step();
      total++;
      if (bus_if.rx_dv !== dv_exp[j] || bus_if.rx_er !== er_exp[j] ||
          bus_if.rxd !== d_exp[j*4 +: 4]) begin
        bad++;
        $display("FAIL sanitise_out j=%0d: rx_dv=%b rx_er=%b rxd=%h, want %b %b %h",
                 j, bus_if.rx_dv, bus_if.rx_er, bus_if.rxd, dv_exp[j], er_exp[j],
                 d_exp[j*4 +: 4]);
      end
      repeat (2) step();
      prev_dv = dv_exp[j];
      prev_er = er_exp[j];
      prev_d  = d_exp[j*4 +: 4];
    end
  endtask

  // Entered at a ce cycle: switch to 10 Mbit/s while cnt=2.
  task automatic test_speed();
    int nhigh;
    int nce;
    int first_low;
    repeat (2) step();
    bus_if.speed_10 = 1'b1;
    repeat (2) step();
    total++;
    if (bus_if.rx_clk !== 1'b0 || bus_if.ce !== 1'b0) begin
      bad++;
      $display("FAIL speed_no_truncate: rx_clk=%b ce=%b, want 0 0",
               bus_if.rx_clk, bus_if.ce);
    end
    step();
    nhigh = 0;
    nce = 0;
    first_low = -1;
    for (int i = 0; i < 50; i++) begin
      if (bus_if.rx_clk === 1'b1) nhigh++;
      if (bus_if.rx_clk === 1'b0 && first_low < 0) first_low = i;
      if (bus_if.ce === 1'b1) nce++;
      if (i == 0) begin
        total++;
        if (bus_if.ce !== 1'b1) begin
          bad++;
          $display("FAIL speed_first_ce: ce=%b, want 1", bus_if.ce);
        end
        bus_if.valid = 1'b1;
        bus_if.err   = 1'b0;
        bus_if.data  = 4'h7;
      end
      if (i == 24) begin
        total++;
        if (bus_if.rxd !== 4'hA) begin
          bad++;
          $display("FAIL slow_hold: rxd=%h, want a", bus_if.rxd);
        end
      end
      if (i == 25) begin
        total++;
        if (bus_if.rxd !== 4'h7 || bus_if.rx_dv !== 1'b1) begin
          bad++;
          $display("FAIL slow_latency: rx_dv=%b rxd=%h, want 1 7", bus_if.rx_dv, bus_if.rxd);
        end
      end
      step();
    end
    total++;
    if (nhigh != 25 || first_low != 25) begin
      bad++;
      $display("FAIL slow_duty: high=%0d first_low=%0d, want 25 25", nhigh, first_low);
    end
    total++;
    if (nce != 1 || bus_if.ce !== 1'b1) begin
      bad++;
      $display("FAIL slow_ce_spacing: ce_in_period=%0d ce_at_50=%b, want 1 1", nce, bus_if.ce);
    end
  endtask

  // Entered at a ce cycle in 10 Mbit/s mode: show F on the pins, reset mid-frame.
  task automatic test_reset_mid();
    logic [1:10] ce_pat;
    bit          seen;
    ce_pat = 10'b0000100001;
    bus_if.speed_10 = 1'b0;
    bus_if.valid = 1'b1;
    bus_if.err   = 1'b0;
    bus_if.data  = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (bus_if.rx_dv === 1'b1 && bus_if.rxd === 4'hF) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL rst_precond: rx_dv=%b rxd=%h, want 1 f within 60 clk",
               bus_if.rx_dv, bus_if.rxd);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus_if.rx_dv !== 1'b0 || bus_if.rx_er !== 1'b0 || bus_if.rxd !== 4'h0 ||
        bus_if.rx_clk !== 1'b0 || bus_if.ce !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: rx_clk=%b ce=%b rx_dv=%b rx_er=%b rxd=%h, want all 0",
               bus_if.rx_clk, bus_if.ce, bus_if.rx_dv, bus_if.rx_er, bus_if.rxd);
    end
    bus_if.valid = 1'b0;
    bus_if.data  = 4'h0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (bus_if.ce !== ce_pat[k] || bus_if.rx_dv !== 1'b0 || bus_if.rxd !== 4'h0) begin
        bad++;
        $display("FAIL rst_release k=%0d: ce=%b rx_dv=%b rxd=%h, want %b 0 0",
                 k, bus_if.ce, bus_if.rx_dv, bus_if.rxd, ce_pat[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_data();
    test_sanitise();
    test_speed();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mii_io_rx.md
Name: mii_io_rx

Overview:
- PHY-side MII receive pin interface.
- Generates the free-running rx_clk from the fast core clock and emits a one-cycle ce strobe per MII nibble period.
- Captures the core's receive nibble/valid/error on ce and drives rx_dv, rx_er and rxd off-chip, updated on the falling edge of rx_clk.
- Sits between the PCS receive path and the package pins; it is the receive-direction counterpart of the MII transmit pin block.

Parameters:
- DIV, 5, clk cycles per rx_clk period at 100 Mbit/s (125 MHz clk gives 25 MHz rx_clk); must be >= 3.
- SLOW_MULT, 10, period multiplier applied in 10 Mbit/s mode (rx_clk = 2.5 MHz).

Ports:
- clk  input  1  core clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- speed_10  input  1  1 = 10 Mbit/s period (DIV*SLOW_MULT); quasi-static.
- ce  output  1  one-cycle strobe, once per MII period.
- valid  input  1  core receive data valid; sampled when ce=1.
- err  input  1  core receive error; sampled when ce=1.
- data  input  4  core receive nibble; sampled when ce=1.
- rx_clk  output  1  off-chip MII receive clock.
- rx_dv  output  1  off-chip receive data valid.
- rx_er  output  1  off-chip receive error.
- rxd  output  4  off-chip receive nibble.

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst_n. No other clock domains.
- Period P = DIV (speed_10=0) or DIV*SLOW_MULT (speed_10=1).
- Down-counter cnt runs P-1 down to 0, then wraps back to P-1.
- speed_10 is sampled only at wrap (cnt=0), so a period is never truncated or stretched mid-way. A change while cnt≠0 takes effect from the next period.
- Reset values (asserted asynchronously): cnt=P-1 per current speed_10, ce=0, rx_clk=0, rx_dv=0, rx_er=0, rxd=0, and all holding registers 0.
- rx_clk is registered: 1 while cnt ≥ P/2 (integer division), else 0.
  - DIV=5: high for 3 clk, low for 2 clk.
  - 10M: high for 25 clk, low for 25 clk.
- ce is registered: 1 for exactly one clk cycle when cnt = P-1, i.e. the first cycle after the rx_clk rising edge. The core must present valid/err/data in that cycle.
- Capture: on the posedge where ce=1, latch valid/err/data into holding registers hv/he/hd.
- Pin update: on the posedge where rx_clk goes 1→0 (cnt transitions P/2 → P/2-1), load rx_dv/rx_er/rxd from the holding registers.
  - Pins are stable for a full rx_clk period around the MAC's rising-edge sample.
  - Setup = low time; hold = high time.
- Latency: core input sampled at ce to pin change = ceil(P/2) clk cycles (3 clk at DIV=5).
- Sanitising, applied at capture:
  - valid=1: rxd=data, rx_er=err.
  - valid=0, err=1: rxd=4'hE, rx_er=1 (false-carrier code).
  - valid=0, err=0: rxd=4'h0, rx_er=0.
- Reset mid-frame: pins drop to 0 immediately and asynchronously. After rst_n deasserts, the first ce occurs in the first cycle with cnt=P-1 following one full period, so no partial nibble is emitted.
- Synthesis: rx_clk, rx_dv, rx_er and rxd are driven from registered output IO cells clocked by clk. Simulation uses plain posedge registers with identical timing.

Decomposition:
- Shared header (io.vh / common.vh): DIV default, SLOW_MULT default, false-carrier code 4'hE.
- Natural sub-module: mii_clk_gen, containing the counter, speed latch, rx_clk and ce generation, and the rx_clk falling-edge strobe.
  - Parameterised on DIV/SLOW_MULT.
  - Reusable later by the transmit pin block.
- Top level keeps the holding registers, sanitising logic and IO cells.

Test Plan:
- Reset then free-run, DIV=5, speed_10=0:
  - rx_clk pattern 1,1,1,0,0 repeating.
  - ce high one cycle in five, in the cycle after rx_clk rises.
  - All pins 0 before the first falling edge.
- Drive valid=1, data=4'h5 for 7 periods, then 4'hD, with err=0:
  - rxd shows 5 ×7 then D, each appearing 3 clk after its ce.
  - rx_dv=1 throughout; stable at every rx_clk rising edge.
- valid=0, err=1, data=4'h3:
  - rx_dv=0, rx_er=1, rxd=4'hE.
  - Then valid=0, err=0 gives rxd=0, rx_er=0.
- valid=1, err=1, data=4'hA (mid-frame error):
  - rx_dv=1, rx_er=1, rxd=4'hA for exactly one rx_clk period.
- Toggle speed_10 0→1 at cnt=2:
  - Current 5-cycle period completes.
  - Next period is 50 clk, with rx_clk high 25 and low 25.
  - ce spacing = 50.
- Assert rst_n=0 asynchronously with rx_dv=1, rxd=4'hF:
  - All pins 0 in the same cycle, without waiting for a clk edge.
  - After release, the first ce arrives one full period later; no stale nibble reappears.
